// File: rtl/booth_pkg.sv
// Shared widths and the radix-4 Booth digit type for the booth_8bit multiplier.
package booth_pkg;

    localparam int W_OP   = 8;
    localparam int W_PROD = 16;
    localparam int N_PP   = 4;

    typedef enum logic [2:0] {
        ZERO,
        POS1,
        POS2,
        NEG1,
        NEG2
    } booth_digit_e;

    // Triplet is (b[2i+1], b[2i], b[2i-1]); the digit value is -2*t[2] + t[1] + t[0].
    function automatic booth_digit_e decode_digit(input logic [2:0] triplet);
        booth_digit_e d;
        case (triplet)
            3'b001, 3'b010: d = POS1;
            3'b011:         d = POS2;
            3'b100:         d = NEG2;
            3'b101, 3'b110: d = NEG1;
            default:        d = ZERO;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_r4_enc.sv
// One radix-4 Booth partial-product generator: selects 0, +-A or +-2A (pre-shift).
module booth_r4_enc
    import booth_pkg::*;
(
    input  logic [2:0]        triplet,
    input  logic [W_OP-1:0]   a,
    output logic [W_PROD-1:0] pp,
    output logic              neg
);

    booth_digit_e        digit;
    logic [W_PROD-1:0]   a_ext;
    logic [W_PROD-1:0]   mag;

    assign digit = decode_digit(triplet);
    assign a_ext = {{(W_PROD - W_OP){a[W_OP-1]}}, a};

    always_comb begin
        mag = '0;
        neg = 1'b0;
        case (digit)
            POS1: mag = a_ext;
            POS2: mag = a_ext << 1;
            NEG1: begin
                mag = a_ext;
                neg = 1'b1;
            end
            NEG2: begin
                mag = a_ext << 1;
                neg = 1'b1;
            end
            default: mag = '0;
        endcase
    end

    // Negative digits emit the one's complement; the +1 is added by the top as `neg`.
    assign pp = neg ? ~mag : mag;

endmodule

// File: rtl/booth_8bit.sv
// Signed 8x8 radix-4 Booth multiplier with a single registered output stage.
module booth_8bit
    import booth_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [W_OP-1:0]     in_a,
    input  logic [W_OP-1:0]     in_b,
    output logic                o_valid,
    output logic [W_PROD-1:0]   o_prod
);

    logic [W_OP:0]       b_ext;
    logic [W_PROD-1:0]   pp [N_PP];
    logic [N_PP-1:0]     neg;
    logic [W_PROD-1:0]   sum;

    assign b_ext = {in_b, 1'b0};

    for (genvar i = 0; i < N_PP; i++) begin : g_pp
        booth_r4_enc u_enc (
            .triplet (b_ext[2*i +: 3]),
            .a       (in_a),
            .pp      (pp[i]),
            .neg     (neg[i])
        );
    end

    // NOTE: combinational accumulation uses blocking '=' so each iteration sees the
    // previous partial sum; the default assignment first keeps it latch-free.
    always_comb begin
        sum = '0;
        for (int k = 0; k < N_PP; k++) begin
            sum = sum + (pp[k] << (2 * k)) + (W_PROD'(neg[k]) << (2 * k));
        end
    end

    // NOTE: state uses non-blocking '<=' so all registers update together on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            o_prod  <= '0;
        end else begin
            o_valid <= in_valid;
            if (in_valid) begin
                o_prod <= sum;
            end
        end
    end

endmodule

// File: tb/tb_booth_8bit.sv
// Scoreboard bench for booth_8bit: directed cases, hold, async reset, exhaustive sweep.
module tb_booth_8bit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        o_valid;
    logic [15:0] o_prod;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [15:0] exp_q[$];
    logic [15:0] last_prod = 16'h0000;

    booth_8bit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_a     (in_a),
        .in_b     (in_b),
        .o_valid  (o_valid),
        .o_prod   (o_prod)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return p[15:0];
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare outputs #1 after the edge: valid flag, then product or hold value.
    task automatic check_out(input string tag, input logic exp_valid);
        chk({tag, ".valid"}, {15'b0, o_valid}, {15'b0, exp_valid});
        if (o_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk({tag, ".unexpected"}, o_prod, 16'hxxxx);
            end else begin
                last_prod = exp_q.pop_front();
                chk({tag, ".prod"}, o_prod, last_prod);
            end
        end else begin
            chk({tag, ".hold"}, o_prod, last_prod);
        end
    endtask

    task automatic drive(input string tag, input logic v, input logic [7:0] a, input logic [7:0] b);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        if (v) exp_q.push_back(model(a, b));
        @(posedge clk);
        #1;
        check_out(tag, v);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_a     = 8'd5;
        in_b     = 8'd3;

        // Reset held across edges with a live capture request.
        repeat (2) @(posedge clk);
        #1;
        chk("rst.prod", o_prod, 16'h0000);
        chk("rst.valid", {15'b0, o_valid}, 16'h0000);

        @(negedge clk);
        rst_n = 1'b1;
        drive("rst_release", 1'b1, 8'd5, 8'd3);

        // Directed signed set, back to back.
        drive("5x3",     1'b1, 8'd5,    8'd3);
        drive("-7x6",    1'b1, 8'hF9,   8'd6);
        drive("-8x-8",   1'b1, 8'hF8,   8'hF8);
        drive("127x-1",  1'b1, 8'd127,  8'hFF);
        drive("-128x2",  1'b1, 8'h80,   8'd2);
        chk("const.-42", model(8'hF9, 8'd6), 16'hFFD6);

        // Extremes.
        drive("-128x-128", 1'b1, 8'h80, 8'h80);
        chk("ext.4000", last_prod, 16'h4000);
        drive("-128x127",  1'b1, 8'h80, 8'd127);
        chk("ext.C080", last_prod, 16'hC080);
        drive("127x127",   1'b1, 8'd127, 8'd127);
        chk("ext.16129", last_prod, 16'd16129);
        drive("0x-128",    1'b1, 8'd0,  8'h80);
        chk("ext.zero", last_prod, 16'h0000);

        // Hold: idle cycle with new operands must not disturb the product.
        drive("hold.load", 1'b1, 8'd5, 8'd3);
        drive("hold.idle", 1'b0, 8'd9, 8'd9);
        chk("hold.15", o_prod, 16'd15);

        // Async reset between edges.
        drive("arst.load", 1'b1, 8'hF9, 8'd6);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.prod", o_prod, 16'h0000);
        chk("arst.valid", {15'b0, o_valid}, 16'h0000);
        exp_q.delete();
        last_prod = 16'h0000;
        @(negedge clk);
        rst_n = 1'b1;
        drive("arst.idle", 1'b0, 8'd1, 8'd1);

        // Exhaustive sweep, one pair per cycle.
        for (int i = 0; i < 65536; i++) begin
            drive("sweep", 1'b1, i[15:8], i[7:0]);
        end
        drive("sweep.drain", 1'b0, 8'd0, 8'd0);
        chk("queue.empty", 16'(exp_q.size()), 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
